// File: rtl/vd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vd_pkg
// Brief   : Shared types and helpers for the cache line state memory
//           (flush FSM state encoding, index width helper).
// Revision: 1.0  initial release
// ============================================================================
package vd_pkg;

  // Flush engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } vd_state_e;

  // Index width for n entries; never narrower than one bit so a
  // direct-mapped cache still gets a legal way index port.
  function automatic int vd_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vd_way_select.sv
`default_nettype none
// ============================================================================
// Module  : vd_way_select
// Brief   : Lowest-index priority encoder over a per-way hit vector.
//           any_hit_o flags a hit, way_o is the lowest set bit position.
// Revision: 1.0  initial release
// ============================================================================
module vd_way_select #(
  parameter int WAYS  = 1,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]  vec_i,
  output logic             any_hit_o,
  output logic [WAY_W-1:0] way_o
);

  // Walk from the top way down so the lowest hitting way is written last
  always_comb begin
    any_hit_o = 1'b0;
    way_o     = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        any_hit_o = 1'b1;
        way_o     = i[WAY_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vd_state_memory.sv
`default_nettype none
// ============================================================================
// Module  : vd_state_memory
// Brief   : Per-line valid/dirty store for a SETS x WAYS cache with a
//           sequenced flush engine that offers each valid+dirty line to the
//           write-back path, then invalidates (keep=0) or cleans (keep=1) it.
// Revision: 1.0  initial release
// ============================================================================
module vd_state_memory
  import vd_pkg::*;
#(
  parameter  int SETS  = 1024,
  parameter  int WAYS  = 1,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = vd_width(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SET_W-1:0] wr_set,
  input  logic [WAY_W-1:0] wr_way,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic [SET_W-1:0] rd_set,
  output logic [WAYS-1:0]  rd_valid,
  output logic [WAYS-1:0]  rd_dirty,
  input  logic             flush_req,
  input  logic             flush_keep,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_valid,
  output logic [SET_W-1:0] wb_set,
  output logic [WAY_W-1:0] wb_way,
  input  logic             wb_ready
);

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  vd_state_e        state_q;
  logic             keep_q;
  logic [SET_W-1:0] scan_q;
  logic [SET_W-1:0] scan_d;
  logic             busy_q;
  logic             done_q;
  logic             wb_valid_q;
  logic [SET_W-1:0] wb_set_q;
  logic [WAY_W-1:0] wb_way_q;

  logic [WAYS-1:0]  scan_hits;
  logic             scan_last;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;

  // Controller reads are zero-latency from the arrays
  assign rd_valid   = valid_q[rd_set];
  assign rd_dirty   = dirty_q[rd_set];

  assign flush_busy = busy_q;
  assign flush_done = done_q;
  assign wb_valid   = wb_valid_q;
  assign wb_set     = wb_set_q;
  assign wb_way     = wb_way_q;

  // Only lines that are both valid and dirty need writing back
  assign scan_hits  = valid_q[scan_q] & dirty_q[scan_q];
  assign scan_last  = (scan_q == SET_W'(SETS - 1));
  assign scan_d     = scan_q + 1'b1;

  vd_way_select #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_way_select (
    .vec_i     (scan_hits),
    .any_hit_o (hit_any),
    .way_o     (hit_way)
  );

  // Line state arrays plus flush FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      state_q    <= ST_IDLE;
      keep_q     <= 1'b0;
      scan_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_set_q   <= '0;
      wb_way_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A write in the same cycle as flush_req lands before the first
          // scan reads the array, so the flush sees it.
          if (wr_en) begin
            valid_q[wr_set][wr_way] <= wr_valid;
            dirty_q[wr_set][wr_way] <= wr_dirty;
          end
          if (flush_req) begin
            keep_q  <= flush_keep;
            scan_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (hit_any) begin
            wb_valid_q <= 1'b1;
            wb_set_q   <= scan_q;
            wb_way_q   <= hit_way;
            state_q    <= ST_WB;
          end else begin
            if (!keep_q) begin
              valid_q[scan_q] <= '0;
            end
            if (scan_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              scan_q <= scan_d;
            end
          end
        end

        ST_WB: begin
          // Offer stays frozen until accepted; then rescan the same set
          if (wb_ready) begin
            dirty_q[wb_set_q][wb_way_q] <= 1'b0;
            if (!keep_q) begin
              valid_q[wb_set_q][wb_way_q] <= 1'b0;
            end
            wb_valid_q <= 1'b0;
            state_q    <= ST_SCAN;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/vd_state_memory.md
Name: vd_state_memory

Overview:
- Parametrised successor of the cache valid-bit store: holds per-line valid and dirty bits for a SETS x WAYS cache.
- Adds a sequenced flush engine that walks every set, hands each valid+dirty line to the write-back path over a valid/ready handshake, then invalidates or cleans the line.
- Sits beside the tag memory; the cache controller reads state combinationally and starts flushes.

Parameters:
- SETS, 1024, number of sets (power of two, >=2)
- WAYS, 1, ways per set (1..8); WAYS=1 is direct-mapped
- SET_W, $clog2(SETS), set index width (derived, localparam)
- WAY_W, max(1,$clog2(WAYS)), way index width (derived, localparam)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  line state write strobe
- wr_set  in  SET_W  set written
- wr_way  in  WAY_W  way written
- wr_valid  in  1  new valid bit
- wr_dirty  in  1  new dirty bit
- rd_set  in  SET_W  set read
- rd_valid  out  WAYS  valid bits of rd_set, one per way
- rd_dirty  out  WAYS  dirty bits of rd_set
- flush_req  in  1  start flush (sampled in IDLE only)
- flush_keep  in  1  sampled with flush_req: 1 = clean only (keep valid), 0 = write back and invalidate
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse at flush end
- wb_valid  out  1  dirty line offered for write-back
- wb_set  out  SET_W  set of offered line
- wb_way  out  WAY_W  way of offered line
- wb_ready  in  1  write-back path accepts line

Behaviour:
- Reset (rst=0, any time, async): all valid/dirty bits 0, FSM IDLE, flush_busy=0, flush_done=0, wb_valid=0, wb_set=0, wb_way=0, scan counter 0. Reset mid-flush aborts with no flush_done pulse.
- Read: rd_valid/rd_dirty are combinational from current array state for rd_set; zero latency. A write takes effect on the next read after the clock edge.
- Write: in IDLE, wr_en=1 updates both bits of (wr_set, wr_way) at the rising edge. While flush_busy=1, wr_en is ignored.
- Write with wr_valid=0 and wr_dirty=1: stored as given; the flush engine acts only on valid&dirty lines.
- FSM states: IDLE, SCAN, WB, DONE.
- IDLE: flush_req=1 latches flush_keep, sets counter=0, goes to SCAN. flush_busy is 1 from the next cycle. Same-cycle wr_en and flush_req: the write is applied and the scan sees it.
- SCAN: examine set[counter]. If any way is valid&dirty, select the lowest-index such way, drive wb_valid=1 with wb_set/wb_way, go to WB.
- SCAN, no dirty way, keep=0: clear all valid bits of the set.
- SCAN, no dirty way, keep=1: leave the set unchanged.
- SCAN, no dirty way, counter=SETS-1: go to DONE; otherwise counter+1 and stay in SCAN. This is one cycle per clean set.
- WB: hold wb_valid, wb_set and wb_way stable until wb_ready=1.
- WB handshake cycle: clear the dirty bit. If keep=0, also clear the valid bit. Deassert wb_valid, return to SCAN on the same set so further dirty ways are found.
- wb_ready while wb_valid=0 is ignored.
- DONE: flush_done=1 for exactly one cycle, flush_busy=0 in that same cycle, return to IDLE.
- flush_req while busy or in DONE is ignored; it is not queued.
- Counter is SET_W bits; the terminal test is counter==SETS-1, with no wrap past it.
- Minimum flush duration, all clean: 1 (IDLE->SCAN) + SETS + 1 (DONE) cycles.

Decomposition:
- Shared package vd_pkg:
  - FSM state enum (IDLE, SCAN, WB, DONE)
  - clog2-based width helper function
- One natural sub-module, vd_way_select: combinational lowest-index priority encoder over the WAYS-bit (valid&dirty) vector. Outputs any_hit and way index.
- Arrays and FSM stay in vd_state_memory.

Test Plan:
- Reset/read, SETS=16, WAYS=4: release rst, write set 5 way 2 valid=1 dirty=0 -> rd_set=5 gives rd_valid=4'b0100 and rd_dirty=4'b0000 the cycle after the write. Assert rst=0 asynchronously mid-cycle -> rd_valid=0 immediately.
- Invalidating flush, no dirty lines: set 3 ways 0,1 valid; flush_req with keep=0 -> busy for 16 SCAN cycles, wb_valid never 1, flush_done pulses once at cycle 18, then rd_valid=0 for set 3.
- Write-back ordering: sets 2 (ways 1,3) and 9 (way 0) valid+dirty; wb_ready held 1 -> offers in order (2,1), (2,3), (9,0); afterwards all rd_valid=0 and rd_dirty=0.
- Backpressure: same as the previous test but wb_ready=0 for 5 cycles on the first offer -> wb_valid, wb_set=2 and wb_way=1 held stable for all 5 cycles; the counter does not advance.
- Clean mode: keep=1 with set 7 way 0 valid+dirty -> one offer (7,0); afterwards rd_valid[0]=1 and rd_dirty[0]=0 for set 7.
- Interference and abort:
  - wr_en during busy -> array unchanged.
  - flush_req during busy -> no second flush_done.
  - rst=0 in WB state -> wb_valid=0 and flush_busy=0 immediately, no flush_done.
